// File: rtl/calc_core.sv
// Multi-cycle add/sub/shift-add multiply/restoring divide engine with registered results and done pulse.
// Optional CALC_BCD_EN adds a double-dabble CONV state and the bcd_o port.
module calc_core #(
  parameter int unsigned W          = 4,
  parameter int unsigned BCD_DIGITS = 3
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [W-1:0]      a_i,
  input  logic [W-1:0]      b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2*W-1:0]    result_o,
  output logic [W-1:0]      rem_o,
  output logic              neg_o,
  output logic              dz_o
`ifdef CALC_BCD_EN
  ,output logic [4*BCD_DIGITS-1:0] bcd_o
`endif
);

  localparam int unsigned RW = 2 * W;
  localparam int unsigned CW = $clog2(2 * W + 1);
  localparam int unsigned BW = 4 * BCD_DIGITS;

  if ((W < 2) || (W > 16) || ((64'd10 ** BCD_DIGITS) <= ((64'd1 << RW) - 64'd1))) begin : g_bad_cfg
    $error("calc_core: W must be 2..16 and BCD_DIGITS must cover 2^(2W)-1");
  end

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CONV, S_DONE} state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [1:0]     op_q;
  logic [W-1:0]   a_q, b_q;
  logic [RW-1:0]  acc_q, mcand_q;
  logic [W-1:0]   mplier_q, quo_q, prem_q;

  logic [RW-1:0]  acc_d, res_d;
  logic [W:0]     div_shift, div_trial;
  logic [W-1:0]   quo_d, prem_d, rem_d;
  logic           neg_d, dz_d, last_c;

`ifdef CALC_BCD_EN
  logic [RW-1:0]  res_q, bin_q, mag_d;
  logic [W-1:0]   rem_q;
  logic           neg_q, dz_q;
  logic [BW-1:0]  bcd_q, bcd_adj, bcd_d;
`endif

  // One iteration of each datapath plus the final values taken on the last EXEC cycle
  always_comb begin
    acc_d     = mplier_q[0] ? acc_q + mcand_q : acc_q;
    div_shift = {prem_q, quo_q[W-1]};
    div_trial = div_shift - {1'b0, b_q};
    if (div_trial[W]) begin
      prem_d = div_shift[W-1:0];
      quo_d  = {quo_q[W-2:0], 1'b0};
    end else begin
      prem_d = div_trial[W-1:0];
      quo_d  = {quo_q[W-2:0], 1'b1};
    end
    last_c = op_q[1] ? (cnt_q == CW'(W - 1)) : (cnt_q == '0);
    res_d  = '0;
    rem_d  = '0;
    neg_d  = 1'b0;
    dz_d   = 1'b0;
    case (op_q)
      2'b00: res_d = RW'(a_q) + RW'(b_q);
      2'b01: begin
        res_d = RW'(a_q) - RW'(b_q);
        neg_d = (a_q < b_q);
      end
      2'b10: begin
        res_d = RW'(quo_d);
        rem_d = prem_d;
        dz_d  = (b_q == '0);
      end
      default: res_d = acc_d;
    endcase
`ifdef CALC_BCD_EN
    mag_d = (op_q == 2'b01 && neg_d) ? RW'(b_q - a_q) : res_d;
`endif
  end

`ifdef CALC_BCD_EN
  // Double-dabble step: add 3 to any digit >= 5, then shift in the next binary bit
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(BCD_DIGITS); i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
    end
    bcd_d = {bcd_adj[BW-2:0], bin_q[RW-1]};
  end
`endif

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      quo_q    <= '0;
      prem_q   <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      result_o <= '0;
      rem_o    <= '0;
      neg_o    <= 1'b0;
      dz_o     <= 1'b0;
`ifdef CALC_BCD_EN
      res_q    <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      bin_q    <= '0;
      bcd_q    <= '0;
      bcd_o    <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_q     <= op_i;
            a_q      <= a_i;
            b_q      <= b_i;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= RW'(a_i);
            mplier_q <= b_i;
            quo_q    <= a_i;
            prem_q   <= '0;
            busy_o   <= 1'b1;
            state_q  <= S_EXEC;
          end
        end
        S_EXEC: begin
          cnt_q    <= cnt_q + CW'(1);
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          quo_q    <= quo_d;
          prem_q   <= prem_d;
          if (last_c) begin
            cnt_q <= '0;
`ifdef CALC_BCD_EN
            res_q   <= res_d;
            rem_q   <= rem_d;
            neg_q   <= neg_d;
            dz_q    <= dz_d;
            bin_q   <= mag_d;
            bcd_q   <= '0;
            state_q <= S_CONV;
`else
            result_o <= res_d;
            rem_o    <= rem_d;
            neg_o    <= neg_d;
            dz_o     <= dz_d;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            state_q  <= S_DONE;
`endif
          end
        end
`ifdef CALC_BCD_EN
        S_CONV: begin
          cnt_q <= cnt_q + CW'(1);
          bcd_q <= bcd_d;
          bin_q <= bin_q << 1;
          if (cnt_q == CW'(RW - 1)) begin
            result_o <= res_q;
            rem_o    <= rem_q;
            neg_o    <= neg_q;
            dz_o     <= dz_q;
            bcd_o    <= bcd_d;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
`endif
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_core.sv
// Scoreboard bench for calc_core (W=4): driver pushes expected results, a monitor pops them on done.
module tb_calc_core;

  localparam int W = 4;
`ifdef CALC_BCD_EN
  localparam int CONV_LAT = 2 * W;
`else
  localparam int CONV_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        clr, start;
  logic [1:0]  op;
  logic [3:0]  a, b;
  logic        busy, done, neg, dz;
  logic [7:0]  result;
  logic [3:0]  rem;
`ifdef CALC_BCD_EN
  logic [11:0] bcd;
`endif

  typedef struct {
    string      name;
    logic [7:0] res;
    logic [3:0] rem;
    logic       neg;
    logic       dz;
    logic [11:0] bcd;
    int         lat;
    int         issue;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  calc_core #(.W(W), .BCD_DIGITS(3)) dut (
    .clk_i    (clk),
    .clr_i    (clr),
    .start_i  (start),
    .op_i     (op),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result),
    .rem_o    (rem),
    .neg_o    (neg),
    .dz_o     (dz)
`ifdef CALC_BCD_EN
    ,.bcd_o   (bcd)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (!clr && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, ".result"}, 32'(result), 32'(e.res));
        chk({e.name, ".rem"},    32'(rem),    32'(e.rem));
        chk({e.name, ".neg"},    32'(neg),    32'(e.neg));
        chk({e.name, ".dz"},     32'(dz),     32'(e.dz));
        chk({e.name, ".busy"},   32'(busy),   32'(0));
        chk({e.name, ".latency"}, 32'(cyc - e.issue), 32'(e.lat));
`ifdef CALC_BCD_EN
        chk({e.name, ".bcd"},    32'(bcd),    32'(e.bcd));
`endif
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%0b expected busy=0 within 60 cycles", busy);
    end
  endtask

  task automatic issue(input string nm, input logic [1:0] o, input logic [3:0] x, input logic [3:0] y,
                       input logic [7:0] r, input logic [3:0] rm, input logic n, input logic d,
                       input logic [11:0] bc);
    exp_t e;
    wait_idle();
    op = o; a = x; b = y; start = 1'b1;
    e.name = nm; e.res = r; e.rem = rm; e.neg = n; e.dz = d; e.bcd = bc;
    e.lat = (o[1] ? W : 1) + CONV_LAT;
    e.issue = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); a = 4'($urandom); b = 4'($urandom);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    chk("reset.busy",   32'(busy),   0);
    chk("reset.done",   32'(done),   0);
    chk("reset.result", 32'(result), 0);
    chk("reset.rem",    32'(rem),    0);
    chk("reset.neg",    32'(neg),    0);
    chk("reset.dz",     32'(dz),     0);
`ifdef CALC_BCD_EN
    chk("reset.bcd",    32'(bcd),    0);
`endif

    issue("add_9_7",    2'b00, 4'd9,  4'd7,  8'h10, 4'd0, 1'b0, 1'b0, 12'h016);
    issue("sub_3_5",    2'b01, 4'd3,  4'd5,  8'hFE, 4'd0, 1'b1, 1'b0, 12'h002);
    issue("mul_15_15",  2'b11, 4'd15, 4'd15, 8'hE1, 4'd0, 1'b0, 1'b0, 12'h225);
    issue("div_13_4",   2'b10, 4'd13, 4'd4,  8'h03, 4'd1, 1'b0, 1'b0, 12'h003);
    issue("div_9_0",    2'b10, 4'd9,  4'd0,  8'h0F, 4'd9, 1'b0, 1'b1, 12'h015);
    issue("add_15_15",  2'b00, 4'd15, 4'd15, 8'h1E, 4'd0, 1'b0, 1'b0, 12'h030);
    issue("sub_7_7",    2'b01, 4'd7,  4'd7,  8'h00, 4'd0, 1'b0, 1'b0, 12'h000);
    issue("sub_0_15",   2'b01, 4'd0,  4'd15, 8'hF1, 4'd0, 1'b1, 1'b0, 12'h015);
    issue("sub_15_0",   2'b01, 4'd15, 4'd0,  8'h0F, 4'd0, 1'b0, 1'b0, 12'h015);
    issue("mul_13_11",  2'b11, 4'd13, 4'd11, 8'h8F, 4'd0, 1'b0, 1'b0, 12'h143);
    issue("mul_0_9",    2'b11, 4'd0,  4'd9,  8'h00, 4'd0, 1'b0, 1'b0, 12'h000);
    issue("div_15_15",  2'b10, 4'd15, 4'd15, 8'h01, 4'd0, 1'b0, 1'b0, 12'h001);
    issue("div_2_7",    2'b10, 4'd2,  4'd7,  8'h00, 4'd2, 1'b0, 1'b0, 12'h000);

    // Start pulsed two cycles into a multiply is dropped
    issue("mul_ignore", 2'b11, 4'd15, 4'd15, 8'hE1, 4'd0, 1'b0, 1'b0, 12'h225);
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 4'd1; b = 4'd1;
    @(negedge clk);
    start = 1'b0;

    // Start during the DONE cycle is dropped
    issue("add_done_ign", 2'b00, 4'd2, 4'd3, 8'h05, 4'd0, 1'b0, 1'b0, 12'h005);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    start = 1'b1; op = 2'b00; a = 4'd1; b = 4'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (CONV_LAT + 6) @(negedge clk);

    // Synchronous clear mid-divide aborts the operation
    issue("div_aborted", 2'b10, 4'd13, 4'd4, 8'h03, 4'd1, 1'b0, 1'b0, 12'h003);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_q.delete();
    chk("clr.busy",   32'(busy),   0);
    chk("clr.done",   32'(done),   0);
    chk("clr.result", 32'(result), 0);
    chk("clr.rem",    32'(rem),    0);
    repeat (CONV_LAT + 8) @(negedge clk);

    issue("div_after_clr", 2'b10, 4'd14, 4'd3, 8'h04, 4'd2, 1'b0, 1'b0, 12'h004);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
